// File: rtl/extract_sequencer.sv
// Extract sequencer: copies up to NUM_FIELDS table-selected fields of a PHV into a key, one field per cycle.
// Optional key counter output o_key_cnt when EXTRACT_SEQ_STATS_EN is defined.
module extract_sequencer #(
    parameter int PHV_WIDTH     = 1024,
    parameter int EXTRACT_WIDTH = 8,
    parameter int OFFSET_WIDTH  = $clog2(PHV_WIDTH/EXTRACT_WIDTH),
    parameter int NUM_FIELDS    = 8,
    localparam int KEY_WIDTH    = NUM_FIELDS*EXTRACT_WIDTH,
    localparam int IDX_WIDTH    = $clog2(NUM_FIELDS),
    localparam int LEN_WIDTH    = $clog2(NUM_FIELDS+1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_phv_valid,
    input  logic [PHV_WIDTH-1:0]    i_phv,
    output logic                    o_phv_ready,
    input  logic                    i_cfg_wren,
    input  logic [IDX_WIDTH-1:0]    i_cfg_addr,
    input  logic [OFFSET_WIDTH-1:0] i_cfg_offset,
    input  logic                    i_cfg_len_wren,
    input  logic [LEN_WIDTH-1:0]    i_cfg_len,
    output logic                    o_cfg_drop,
    output logic                    o_key_valid,
    input  logic                    i_key_ready,
    output logic [KEY_WIDTH-1:0]    o_key
`ifdef EXTRACT_SEQ_STATS_EN
    ,
    output logic [31:0]             o_key_cnt
`endif
);

    localparam int NUM_SLOTS = PHV_WIDTH/EXTRACT_WIDTH;

    typedef enum logic [1:0] {IDLE, EXTRACT, OUTPUT} state_t;

    state_t                   state;
    state_t                   next_state;

    logic [EXTRACT_WIDTH-1:0] phv_fields  [NUM_SLOTS];
    logic [OFFSET_WIDTH-1:0]  offset_tbl  [NUM_FIELDS];
    logic [OFFSET_WIDTH-1:0]  offset_snap [NUM_FIELDS];
    logic [EXTRACT_WIDTH-1:0] key_fields  [NUM_FIELDS];
    logic [LEN_WIDTH-1:0]     len_cfg;
    logic [LEN_WIDTH-1:0]     len_snap;
    logic [IDX_WIDTH-1:0]     idx;

    logic accept;
    logic handshake;
    logic last_field;
    logic cfg_req;

    assign accept     = i_phv_valid && o_phv_ready;
    assign handshake  = o_key_valid && i_key_ready;
    assign cfg_req    = i_cfg_wren || i_cfg_len_wren;
    assign last_field = (LEN_WIDTH'(idx) == (len_snap - LEN_WIDTH'(1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (len_cfg == '0) ? OUTPUT : EXTRACT;
                end
            end
            EXTRACT: begin
                if (last_field) begin
                    next_state = OUTPUT;
                end
            end
            OUTPUT: begin
                if (handshake) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        o_phv_ready = 1'b0;
        o_key_valid = 1'b0;
        o_cfg_drop  = 1'b0;
        o_phv_ready = i_rst_n && (state == IDLE);
        o_key_valid = (state == OUTPUT);
        o_cfg_drop  = (state != IDLE) && cfg_req;
    end

    // The table and length are snapshotted at accept so a same-cycle config write only affects later packets.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                phv_fields[i] <= '0;
            end
            for (int n = 0; n < NUM_FIELDS; n++) begin
                offset_tbl[n]  <= '0;
                offset_snap[n] <= '0;
                key_fields[n]  <= '0;
            end
            len_cfg  <= '0;
            len_snap <= '0;
            idx      <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    phv_fields[i] <= i_phv[i*EXTRACT_WIDTH +: EXTRACT_WIDTH];
                end
                for (int n = 0; n < NUM_FIELDS; n++) begin
                    key_fields[n]  <= '0;
                    offset_snap[n] <= offset_tbl[n];
                end
                len_snap <= len_cfg;
                idx      <= '0;
            end
            if (i_cfg_wren) begin
                offset_tbl[i_cfg_addr] <= i_cfg_offset;
            end
            if (i_cfg_len_wren) begin
                len_cfg <= (i_cfg_len > LEN_WIDTH'(NUM_FIELDS)) ? LEN_WIDTH'(NUM_FIELDS) : i_cfg_len;
            end
        end else if (state == EXTRACT) begin
            key_fields[idx] <= phv_fields[offset_snap[idx]];
            idx             <= idx + IDX_WIDTH'(1);
        end
    end

    for (genvar n = 0; n < NUM_FIELDS; n++) begin : g_key
        assign o_key[n*EXTRACT_WIDTH +: EXTRACT_WIDTH] = key_fields[n];
    end

`ifdef EXTRACT_SEQ_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_key_cnt <= '0;
        end else if (handshake) begin
            o_key_cnt <= o_key_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/extract_sequencer.md
EXTRACT_SEQUENCER -- requirements
Module: extract_sequencer

Interface
REQ-001 Parameter PHV_WIDTH, default 1024, PHV width in bits.
REQ-002 Parameter EXTRACT_WIDTH, default 8, width of one extracted field.
REQ-003 Parameter OFFSET_WIDTH, default $clog2(PHV_WIDTH/EXTRACT_WIDTH), field-index width.
REQ-004 Parameter NUM_FIELDS, default 8, offset-table depth and key field count.
REQ-005 Localparams: KEY_WIDTH=NUM_FIELDS*EXTRACT_WIDTH; IDX_WIDTH=$clog2(NUM_FIELDS); LEN_WIDTH=$clog2(NUM_FIELDS+1).
REQ-006 i_clk  input  1  sole clock, rising edge.
REQ-007 i_rst_n  input  1  asynchronous active-low reset.
REQ-008 i_phv_valid  input  1  PHV present.
REQ-009 i_phv  input  PHV_WIDTH  PHV data.
REQ-010 o_phv_ready  output  1  PHV accepted when high with i_phv_valid.
REQ-011 i_cfg_wren  input  1  table write strobe.
REQ-012 i_cfg_addr  input  IDX_WIDTH  table entry index.
REQ-013 i_cfg_offset  input  OFFSET_WIDTH  field index for that entry.
REQ-014 i_cfg_len_wren  input  1  field-count write strobe.
REQ-015 i_cfg_len  input  LEN_WIDTH  number of fields to extract.
REQ-016 o_cfg_drop  output  1  one-cycle pulse: config write ignored.
REQ-017 o_key_valid  output  1  key available.
REQ-018 o_key  output  KEY_WIDTH  extracted key; field n at bits [n*EXTRACT_WIDTH +: EXTRACT_WIDTH].
REQ-019 i_key_ready  input  1  downstream accepts key.

Function
REQ-020 FSM states IDLE, EXTRACT, OUTPUT; o_phv_ready = (state==IDLE).
REQ-021 IDLE: on i_phv_valid&o_phv_ready, latch i_phv, clear key to zero, idx=0; go EXTRACT if len!=0, else OUTPUT.
REQ-022 EXTRACT: each cycle key[idx] <= phv_latched[offset_tbl[idx]*EXTRACT_WIDTH +: EXTRACT_WIDTH]; idx increments; after idx==len-1 go OUTPUT.
REQ-023 Latency: PHV accepted at edge T -> o_key_valid high after edge T+len (T for len=0).
REQ-024 OUTPUT: o_key_valid=1, o_key stable until o_key_valid&i_key_ready; that edge returns to IDLE; no PHV accepted in that same cycle.
REQ-025 Key fields at index >= len read zero.
REQ-026 Config writes act only in IDLE; in EXTRACT/OUTPUT write is discarded and o_cfg_drop pulses 1 for that cycle.
REQ-027 Simultaneous PHV accept and config write in IDLE: write takes effect, the accepted PHV uses pre-write table/len values.
REQ-028 i_cfg_len > NUM_FIELDS saturates to NUM_FIELDS when stored.
REQ-029 Offset table and len are not cleared by PHV traffic; contents persist until rewritten or reset.

Reset
REQ-030 i_rst_n low asynchronously forces state IDLE, idx 0, key 0, latched PHV 0, offset table all 0, len 0.
REQ-031 Reset outputs: o_phv_ready=0 during reset then 1, o_key_valid=0, o_key=0, o_cfg_drop=0.
REQ-032 Reset mid-EXTRACT/OUTPUT abandons the packet; no key emitted for it.

Configuration
REQ-033 Macro EXTRACT_SEQ_STATS_EN defined: adds output o_key_cnt, 32 bits, reset 0, increments on each o_key_valid&i_key_ready, wraps 0xFFFFFFFF->0.
REQ-034 EXTRACT_SEQ_STATS_EN undefined: port and counter absent; all other behaviour identical.

Verification
REQ-035 Table {0:5,1:0,2:127}, len=3, PHV byte k = k -> key bytes {0x05,0x00,0x7F}, others 0, valid 3 cycles after accept.
REQ-036 len=0, PHV sent -> o_key_valid next cycle with o_key=0.
REQ-037 i_key_ready held low 10 cycles in OUTPUT -> o_key stable, o_phv_ready=0, second PHV stalled, accepted the cycle after handshake.
REQ-038 Config write during EXTRACT -> o_cfg_drop pulse 1 cycle, table unchanged, key per old table.
REQ-039 i_cfg_len=15 with NUM_FIELDS=8 -> 8 fields extracted, valid 8 cycles after accept.
REQ-040 i_rst_n asserted mid-EXTRACT -> o_key_valid=0, o_key=0, table cleared; with EXTRACT_SEQ_STATS_EN, o_key_cnt=0.
